// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   FIFO controller for an external single-write / single-read RAM with a
//   1-cycle read latency. Upstream words are written straight into the RAM.
//   Reads are prefetched into a 2-entry output buffer, so the downstream
//   stream can pop one word per cycle. Capacity is 2**ADDR_WIDTH + 2 words.
//
//   Optional feature macro: RAM_FIFO_AFULL_EN
//     defined   -> registered almost_full output, AFULL_MARGIN parameter
//     undefined -> neither the port nor the parameter exists
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream valid/ready stream
//   out_valid/out_ready/out_data  downstream valid/ready stream (head word)
//   ram_wr_en/addr/data   RAM write port
//   ram_rd_en/addr        RAM read port, ram_rd_data returns one cycle later
//   level                 words held: RAM + in-flight read + output buffer
//   almost_full           free slots <= AFULL_MARGIN (macro builds only)
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
`ifdef RAM_FIFO_AFULL_EN
  ,
  parameter int AFULL_MARGIN = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH+1:0] level
`ifdef RAM_FIFO_AFULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int NUM_SLOTS = 2;
  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  // registered state
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

  // combinational helpers
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic [2:0]            occ_after;
  logic [1:0]            slot;
  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] shifted;

  // Buffer contents after a pop: every slot takes its upper neighbour, the
  // top slot keeps its (now stale) value.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < NUM_SLOTS - 1) begin : g_shift
        assign shifted[gi] = buf_q[gi+1];
      end else begin : g_top
        assign shifted[gi] = buf_q[gi];
      end
    end
  endgenerate

  always_comb begin
    push = in_valid & in_ready_q;
    pop  = (buf_cnt_q != 2'd0) & out_ready;

    // Buffer slots that remain claimed once this cycle's pop is taken:
    // already-held words plus the read in flight.
    occ_after = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};

    // Only committed words (registered ram_cnt) are read, so a read can
    // never target the address being written in the same cycle.
    rd_issue = (ram_cnt_q != '0) && (occ_after < 3'd2);

    ram_cnt_d  = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, rd_issue};
    wr_ptr_d   = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, rd_issue};
    rd_pend_d  = rd_issue;
    in_ready_d = (ram_cnt_d != RAM_DEPTH);

    // Returning read data lands just behind whatever survives the pop.
    slot      = buf_cnt_q - {1'b0, pop};
    buf_cnt_d = slot + {1'b0, rd_pend_q};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      buf_d[i] = pop ? shifted[i] : buf_q[i];
      if (rd_pend_q && (slot == i[1:0])) begin
        buf_d[i] = ram_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      buf_cnt_q  <= 2'd0;
      in_ready_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      buf_cnt_q  <= buf_cnt_d;
      in_ready_q <= in_ready_d;
      buf_q      <= buf_d;
    end
  end

`ifdef RAM_FIFO_AFULL_EN
  localparam int CAPACITY = (1 << ADDR_WIDTH) + NUM_SLOTS;
  localparam logic [ADDR_WIDTH+1:0] AFULL_LEVEL = (ADDR_WIDTH+2)'(CAPACITY - AFULL_MARGIN);

  logic [ADDR_WIDTH+1:0] level_d;
  logic                  almost_full_q, almost_full_d;

  // Registered from next-state occupancy so the flag lines up with level.
  always_comb begin
    level_d = {1'b0, ram_cnt_d} + {{(ADDR_WIDTH+1){1'b0}}, rd_pend_d}
            + {{ADDR_WIDTH{1'b0}}, buf_cnt_d};
    almost_full_d = (level_d >= AFULL_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = (buf_cnt_q != 2'd0);
  assign out_data    = buf_q[0];
  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = rd_issue;
  assign ram_rd_addr = rd_ptr_q;
  assign level       = {1'b0, ram_cnt_q} + {{(ADDR_WIDTH+1){1'b0}}, rd_pend_q}
                     + {{ADDR_WIDTH{1'b0}}, buf_cnt_q};

endmodule
